// File: rtl/fetch_queue.sv
// fetch_queue: PC generator feeding a circular instruction queue, with redirect flush.
module fetch_queue #(
  parameter int XLEN = 32,
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic [XLEN-1:0]            imem_addr,
  input  logic [XLEN-1:0]            imem_data,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_instr,
  output logic [XLEN-1:0]            out_pc,
  output logic [XLEN-1:0]            out_pc_plus4,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_mem [DEPTH];
  logic [XLEN-1:0] instr_mem [DEPTH];
  logic [AW-1:0] head, tail;
  logic pop, push;
  assign imem_addr = pc;
  assign out_valid = (count != '0) && !redirect_valid;
  assign pop = out_valid && out_ready;
  // A full queue may still accept a fetch when the head leaves in the same cycle.
  assign push = !redirect_valid && ((count < CW'(DEPTH)) || pop);
  assign out_instr = instr_mem[head];
  assign out_pc = pc_mem[head];
  assign out_pc_plus4 = pc_mem[head] + XLEN'(4);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
      count <= '0;
      head <= '0;
      tail <= '0;
    end else if (redirect_valid) begin
      pc <= {redirect_pc[XLEN-1:2], 2'b00};
      count <= '0;
      head <= '0;
      tail <= '0;
    end else begin
      if (push) begin
        pc <= pc + XLEN'(4);
        tail <= tail + AW'(1);
      end
      if (pop) head <= head + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[tail] <= pc;
      instr_mem[tail] <= imem_data;
    end
  end
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter XLEN, default 32: PC and instruction width.
REQ-002 Parameter DEPTH, default 4: instruction-queue entries; power of two, >= 2.
REQ-003 Parameter RESET_PC, default 0: PC value loaded on reset; bits [1:0] are zero.
REQ-004 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1: asynchronous, active-high reset.
REQ-006 Port imem_addr, output, XLEN: fetch address, equal to the current PC (combinational from the PC register).
REQ-007 Port imem_data, input, XLEN: instruction word at imem_addr, valid in the same cycle (combinational ROM).
REQ-008 Port redirect_valid, input, 1: branch/jump taken; flush and refetch.
REQ-009 Port redirect_pc, input, XLEN: target PC for a redirect.
REQ-010 Port out_valid, output, 1: the head entry is valid.
REQ-011 Port out_ready, input, 1: consumer accepts the head entry this cycle.
REQ-012 Port out_instr, output, XLEN: instruction at the queue head.
REQ-013 Port out_pc, output, XLEN: PC of the head instruction.
REQ-014 Port out_pc_plus4, output, XLEN: out_pc + 4, modulo 2^XLEN.
REQ-015 Port count, output, clog2(DEPTH+1): number of occupied entries.

Function
REQ-016 pop = out_valid & out_ready; push = !redirect_valid & (count < DEPTH | pop).
REQ-017 On push, {PC, imem_data} is written at the tail, the tail advances by 1 modulo DEPTH, and PC <= PC + 4 (wraps modulo 2^XLEN).
REQ-018 On pop, the head advances by 1 modulo DEPTH.
REQ-019 count update: +1 on push only, -1 on pop only, unchanged when both occur or neither occurs.
REQ-020 Full (count == DEPTH) with no pop: no push, and PC holds.
REQ-021 Full with a pop in the same cycle: push and pop both occur, and count stays at DEPTH.
REQ-022 Empty (count == 0): out_valid = 0. out_instr and out_pc are don't-care, and the consumer must not use them.
REQ-023 out_valid = (count != 0) & !redirect_valid. A redirect cycle never pops.
REQ-024 Redirect has priority over push and pop. On the next edge: count <= 0, head <= 0, tail <= 0, and PC <= {redirect_pc[XLEN-1:2], 2'b00}.
REQ-025 The first instruction at the redirect target is pushed in the cycle after the redirect, and appears at out_* one cycle after that.
REQ-026 Back-to-back redirects: the last one wins, and nothing is pushed until redirect_valid deasserts.
REQ-027 When out_valid = 1 and out_ready = 0, out_instr and out_pc are held stable until popped or flushed.
REQ-028 Best-case latency: 1 cycle from PC presentation to out_valid. Sustained throughput is 1 instruction per cycle while out_ready = 1.
REQ-029 No combinational path from out_ready to imem_addr.

Reset
REQ-030 While rst = 1, asynchronously: PC = RESET_PC, count = 0, head = tail = 0, out_valid = 0.
REQ-031 Queue storage contents are not reset.
REQ-032 Reset asserted mid-operation discards all queued entries. The first fetch after deassertion uses RESET_PC.
REQ-033 After reset deassertion, the first push occurs on the first rising edge at which rst = 0.

Verification
REQ-034 Streaming: reset, RESET_PC = 0, out_ready = 1 constant, ROM word = address -> out_pc = 0, 4, 8, ... on consecutive cycles; out_instr == out_pc; count stays at 1.
REQ-035 Backpressure: out_ready = 0 for 6 cycles -> count reaches 4 after 4 edges then holds; imem_addr holds at 16; head out_pc = 0 stays stable. Then out_ready = 1 -> out_pc = 0, 4, 8, 12, 16 with no gap or duplicate.
REQ-036 Full plus simultaneous pop: queue full, out_ready = 1 for one cycle -> count stays at 4, PC advances 16 -> 20, head becomes out_pc = 4.
REQ-037 Redirect: redirect_valid for one cycle with redirect_pc = 0x103 while 3 entries are queued -> out_valid = 0 in the redirect cycle and the next; count = 0 then 1; then out_pc = 0x100, 0x104, ... with no stale entry emitted.
REQ-038 Wrap and reset: RESET_PC = 0xFFFFFFF8 -> out_pc = 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000; out_pc_plus4 of the last is 4. Assert rst asynchronously mid-stream -> out_valid drops immediately, count = 0.
REQ-039 Parameter sweep: DEPTH = 2 and DEPTH = 8 -> full at count = DEPTH; pointer wrap over at least 3 full laps keeps in-order PCs.
